// File: rtl/sum_nk_accum_if.sv
// Handshake and operand bus for sum_nk_accum.
// The requester (master) drives start/nums; the summer (slave) returns busy/done/sum.
interface sum_nk_accum_if #(
    parameter int N = 40,
    parameter int W = 5
);
    localparam int OW = W + $clog2(N);

    logic            start;
    logic [N*W-1:0]  nums;
    logic            busy;
    logic            done;
    logic [OW-1:0]   sum;

    modport master (output start, output nums, input busy, input done, input sum);
    modport slave  (input start, input nums, output busy, output done, output sum);
endinterface

// File: rtl/sum_nk_accum.sv
// sum_nk_accum: multi-cycle summer of N W-bit operands using LANES adders.
// Operands are captured on accept, streamed LANES at a time into lane
// accumulators, then the lanes are folded pairwise into acc[0].
// Optional macro SUM_SIGNED_EN: operands treated as two's complement.
module sum_nk_accum #(
    parameter int N     = 40,
    parameter int W     = 5,
    parameter int LANES = 6
) (
    input  logic             clk,
    input  logic             rst,
    sum_nk_accum_if.slave    bus
);
    localparam int OW = W + $clog2(N);
    localparam int C1 = (N + LANES - 1) / LANES;   // accumulate cycles
    localparam int R  = $clog2(LANES);             // reduce cycles
    localparam int L  = C1 + R;                    // accept-to-completion edges
    localparam int CW = $clog2(L + 1);
    localparam int NP = C1 * LANES;                // operand slots incl. zero padding
    localparam int RM = (R > 0) ? R : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, REDUCE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [OW-1:0]   sum_q;
    logic [W-1:0]    cap_q     [NP];
    logic [OW-1:0]   acc_q     [LANES];
    logic [OW-1:0]   acc_d     [LANES];

    logic [W-1:0]    nums_pad  [NP];
    logic [W-1:0]    cap_shift [NP];
    logic [OW-1:0]   ext       [LANES];
    logic [OW-1:0]   pair_w    [LANES][RM];

    logic            last_step;

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign last_step = (cnt_q == CW'(L - 1));

    genvar gi, gs;
    generate
        // Padded capture image and the shift-down-by-LANES view of the capture register.
        for (gi = 0; gi < NP; gi++) begin : g_slot
            if (gi < N) begin : g_real
                assign nums_pad[gi] = bus.nums[gi*W +: W];
            end else begin : g_pad
                assign nums_pad[gi] = '0;
            end
            if (gi + LANES < NP) begin : g_sh
                assign cap_shift[gi] = cap_q[gi + LANES];
            end else begin : g_sh0
                assign cap_shift[gi] = '0;
            end
        end

        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // Lane i always consumes the head slot i of the shifting capture register.
`ifdef SUM_SIGNED_EN
            assign ext[gi] = {{(OW-W){cap_q[gi][W-1]}}, cap_q[gi]};
`else
            assign ext[gi] = {{(OW-W){1'b0}}, cap_q[gi]};
`endif
            // Partner value for each reduce step; zero where lane gi is not a receiver.
            for (gs = 0; gs < RM; gs++) begin : g_red
                if ((R > 0) && (gi % (2 ** (gs + 1)) == 0) && (gi + 2 ** gs < LANES)) begin : g_pair
                    assign pair_w[gi][gs] = acc_q[gi + 2 ** gs];
                end else begin : g_nopair
                    assign pair_w[gi][gs] = '0;
                end
            end
        end
    endgenerate

    // Next lane accumulator values for the current accumulate or reduce step.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            acc_d[j] = acc_q[j];
            if (state_q == ACCUM) begin
                acc_d[j] = acc_q[j] + ext[j];
            end else if (state_q == REDUCE) begin
                for (int s = 0; s < RM; s++) begin
                    if (cnt_q == CW'(C1 + s)) begin
                        acc_d[j] = acc_q[j] + pair_w[j][s];
                    end
                end
            end
        end
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            for (int k = 0; k < NP; k++) cap_q[k] <= '0;
            for (int j = 0; j < LANES; j++) acc_q[j] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < NP; k++) cap_q[k] <= nums_pad[k];
                        for (int j = 0; j < LANES; j++) acc_q[j] <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    for (int j = 0; j < LANES; j++) acc_q[j] <= acc_d[j];
                    for (int k = 0; k < NP; k++) cap_q[k] <= cap_shift[k];
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        sum_q   <= acc_d[0];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == CW'(C1 - 1)) begin
                        state_q <= REDUCE;
                    end
                end
                REDUCE: begin
                    for (int j = 0; j < LANES; j++) acc_q[j] <= acc_d[j];
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        sum_q   <= acc_d[0];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sum_nk_accum.sv
// Directed bench for sum_nk_accum: default build plus two small configurations.
module tb_sum_nk_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    sum_nk_accum_if #(.N(40), .W(5)) b0 ();
    sum_nk_accum_if #(.N(4),  .W(5)) b1 ();
    sum_nk_accum_if #(.N(4),  .W(5)) b2 ();

    sum_nk_accum #(.N(40), .W(5), .LANES(6)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    sum_nk_accum #(.N(4),  .W(5), .LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    sum_nk_accum #(.N(4),  .W(5), .LANES(4)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic logic [199:0] fill40(input logic [4:0] v);
        logic [199:0] r;
        for (int k = 0; k < 40; k++) r[k*5 +: 5] = v;
        return r;
    endfunction

    // One default-config operation; nums optionally zeroed right after accept.
    task automatic op0(input logic [199:0] v, input bit zero_after,
                       output int lat, output int busy_cyc);
        @(negedge clk);
        b0.start = 1'b1;
        b0.nums  = v;
        @(negedge clk);
        b0.start = 1'b0;
        if (zero_after) b0.nums = '0;
        lat = -1;
        busy_cyc = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (b0.busy) busy_cyc++;
            if (b0.done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("op0_timeout", lat, 10);
    endtask

    // One small-config operation on dut1 (which=1) or dut2 (which=2).
    task automatic run_small(input int which, input logic [19:0] v,
                             input int exp_lat, input int exp_sum, input string tag);
        int lat;
        @(negedge clk);
        if (which == 1) begin b1.start = 1'b1; b1.nums = v; end
        else            begin b2.start = 1'b1; b2.nums = v; end
        @(negedge clk);
        b1.start = 1'b0;
        b2.start = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if ((which == 1) ? b1.done : b2.done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_sum"}, int'((which == 1) ? b1.sum : b2.sum), exp_sum);
    endtask

    initial begin
        int lat, bc, dones;
        logic [199:0] pat;

        b0.start = 1'b0; b0.nums = '0;
        b1.start = 1'b0; b1.nums = '0;
        b2.start = 1'b0; b2.nums = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(b0.busy), 0);
        check("reset_done", int'(b0.done), 0);
        check("reset_sum",  int'(b0.sum), 0);
        check("reset_sum_small", int'(b1.sum) + int'(b2.sum), 0);
        rst = 1'b0;

        // All operands 31: unsigned 1240, signed -40 (11'h7D8).
        op0(fill40(5'd31), 1'b0, lat, bc);
        check("all31_latency", lat, 10);
        check("all31_busy_cycles", bc, 10);
`ifdef SUM_SIGNED_EN
        check("all31_sum", int'(b0.sum), 'h7D8);
`else
        check("all31_sum", int'(b0.sum), 1240);
`endif
        @(negedge clk);
        check("done_one_cycle", int'(b0.done), 0);
        check("sum_held", int'(b0.sum), int'(b0.sum === 11'd1240 || b0.sum === 11'h7D8) ? int'(b0.sum) : -1);

        // All operands 15: 600 in either build.
        op0(fill40(5'd15), 1'b0, lat, bc);
        check("all15_sum", int'(b0.sum), 600);

        // Operand k = (k+1) mod 32, nums zeroed after accept.
        for (int k = 0; k < 40; k++) pat[k*5 +: 5] = 5'((k + 1) % 32);
        op0(pat, 1'b1, lat, bc);
`ifdef SUM_SIGNED_EN
        check("capture_sum", int'(b0.sum), 20);
`else
        check("capture_sum", int'(b0.sum), 532);
`endif

        // Ignored starts mid-operation, then back-to-back start in the done cycle.
        @(negedge clk);
        b0.start = 1'b1;
        b0.nums  = fill40(5'd3);
        @(negedge clk);
        b0.start = 1'b0;
        dones = 0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (b0.done) begin
                dones++;
                lat = k;
                break;
            end
            if (k == 3 || k == 6) begin
                b0.start = 1'b1;
                b0.nums  = fill40(5'd2);
            end else begin
                b0.start = 1'b0;
                b0.nums  = '0;
            end
        end
        check("ignored_start_latency", lat, 10);
        check("ignored_start_sum", int'(b0.sum), 120);
        b0.start = 1'b1;
        b0.nums  = fill40(5'd2);
        @(negedge clk);
        b0.start = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 5) check("b2b_sum_holds", int'(b0.sum), 120);
            if (b0.done) begin
                dones++;
                lat = k;
                break;
            end
        end
        check("b2b_latency", lat, 10);
        check("b2b_sum", int'(b0.sum), 80);
        check("total_dones", dones, 2);

        // Reset in the middle of an operation.
        @(negedge clk);
        b0.start = 1'b1;
        b0.nums  = fill40(5'd7);
        @(negedge clk);
        b0.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(b0.busy), 0);
        check("abort_sum",  int'(b0.sum), 0);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (b0.done) dones++;
        end
        check("abort_no_done", dones, 0);
        op0(fill40(5'd7), 1'b0, lat, bc);
        check("after_abort_latency", lat, 10);
        check("after_abort_sum", int'(b0.sum), 280);

        // Small configurations.
        run_small(1, {5'd4, 5'd3, 5'd2, 5'd1}, 4, 10, "n4_l1");
`ifdef SUM_SIGNED_EN
        run_small(2, {5'd1, 5'd0, 5'd0, 5'd31}, 3, 0, "n4_l4");
`else
        run_small(2, {5'd1, 5'd0, 5'd0, 5'd31}, 3, 32, "n4_l4");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/sum_nk_accum.md
Name: sum_nk_accum

Overview:
- Parameterised successor to the fixed 40-operand, 6-adder multi-cycle summer.
- Sums N unsigned (optionally signed) W-bit operands using LANES parallel adders over multiple cycles.
- Has a start/busy/done handshake, captures its operands, and holds a registered result.
- Sits alongside the other generated summers as the general-purpose instance.

Parameters:
- N, 40, number of operands; N >= 2.
- W, 5, operand width in bits.
- LANES, 6, parallel adder lanes; 1 <= LANES <= N.
- OW, W + $clog2(N), result width (derived localparam, not overridable); overflow is impossible.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to sum `nums`; honoured only while busy=0.
- nums  input  N*W  flattened operands; operand k is nums[k*W +: W], k = 0..N-1.
- busy  output  1  high from accept edge until the done cycle.
- done  output  1  one-cycle pulse; sum is valid from this cycle.
- sum  output  OW  registered total; held until the next completion.

Behaviour:
- Derived constants: C1 = ceil(N/LANES) accumulate cycles; R = ceil(log2(LANES)) reduce cycles (R = 0 when LANES = 1); latency L = C1 + R.
- States: IDLE, ACCUM, REDUCE. A cycle counter of width $clog2(L+1) tracks the step.
- Reset (clk edge with rst=1):
  - state goes to IDLE; busy=0, done=0, sum=0.
  - All lane accumulators and the capture register are cleared.
  - rst overrides start and aborts any in-flight operation with no done pulse.
- Accept edge E0: IDLE and start=1.
  - nums is copied to the capture register and lane accumulators are cleared.
  - Moves to ACCUM; busy=1 from the following cycle.
  - nums may change freely after E0.
- ACCUM, edges E1..E(C1), step c = 0..C1-1:
  - lane i does acc[i] += operand(c*LANES + i).
  - Indices >= N contribute 0; this covers the partial last step when N is not a multiple of LANES.
  - Operands are zero-extended to OW, or sign-extended with SUM_SIGNED_EN.
- REDUCE, edges E(C1+1)..E(C1+R), step s = 0..R-1:
  - For each j that is a multiple of 2^(s+1) with j + 2^s < LANES: acc[j] += acc[j + 2^s].
  - After R steps acc[0] holds the total.
- Completion edge E(L):
  - sum <= final total. When R = 0, the final total is acc[0] plus the last accumulate term.
  - done=1 and busy=0 in the cycle after E(L); state returns to IDLE.
  - done drops after exactly one cycle.
- start while busy=1 is ignored. It is neither queued nor able to corrupt the operation in progress.
- start=1 during the done cycle is accepted; back-to-back operations run with no idle gap.
- sum changes only at a completion edge or at reset. It keeps the previous result during a new operation.
- Arithmetic is modulo 2^OW. With the default N and W the full range fits, so no wrap occurs.

Optional Feature:
- Macro: SUM_SIGNED_EN.
- Defined: operands are two's complement, sign-extended to OW, and sum is a two's-complement result. Range is -N*2^(W-1) .. N*(2^(W-1)-1); OW is sufficient.
- Not defined: operands are unsigned and zero-extended; sum is unsigned, range 0..N*(2^W-1).
- Handshake and latency are identical in both builds.

Test Plan:
- Defaults, all operands 31, start pulse:
  - done exactly 10 cycles after the accept edge (C1=7, R=3); sum=1240; busy high for 10 cycles.
  - The partial last accumulate step (lanes 4,5 idle) is exercised.
- Defaults, operand k = (k+1) mod 32, then nums driven to all-zero the cycle after accept → sum=532 (capture check).
- Defaults, second start pulsed at cycles 3 and 6 of a busy period:
  - exactly one done; sum matches the first operand set.
  - Then start asserted during the done cycle → second result 10 cycles later; sum holds the first value meanwhile.
- Defaults, rst asserted at cycle 5 of an operation → no done, busy=0 and sum=0 next cycle; a fresh start after reset gives the correct sum.
- N=4, W=5, LANES=1, operands 1,2,3,4 → done 4 cycles after accept, sum=10.
- N=4, W=5, LANES=4, operands 31,0,0,1 → done 3 cycles after accept (C1=1, R=2), sum=32.
- SUM_SIGNED_EN defined, defaults, all operands 5'b11111 → sum = -40 (11'h7D8); all operands 5'b01111 → sum=600.
